// File: rtl/mxu_feeder.sv
// mxu_feeder: streams job vectors into an MXU wrapper, flushes the
// array pipeline, and emits one m_valid per accepted vector.
// Ports:
//   clk, reset (async, active-low)
//   start, vec_count, data_type      : job control
//   s_data, s_valid, s_ready         : input vector stream
//   input_data, enable*, data_type_o : MXU wrapper drive
//   y                                : MXU wrapper result
//   m_data, m_valid, busy, done      : result stream and job status
module mxu_feeder #(
   parameter int K                      = 3,
   parameter int M                      = 3,
   parameter int max_data_width         = 4,
   parameter int CORE_LAT               = 1,
   parameter int LEN_W                  = 8,
   parameter int LOG_ALLOWED_PRECISIONS = 2
) (
   input  logic                                clk,
   input  logic                                reset,
   input  logic                                start,
   input  logic [LEN_W-1:0]                    vec_count,
   input  logic [LOG_ALLOWED_PRECISIONS-1:0]   data_type,
   input  logic [K*max_data_width-1:0]         s_data,
   input  logic                                s_valid,
   output logic                                s_ready,
   output logic [K*max_data_width-1:0]         input_data,
   output logic                                enable,
   output logic                                enable_in_ff,
   output logic                                enable_chain,
   output logic                                enable_out_ff,
   output logic [LOG_ALLOWED_PRECISIONS-1:0]   data_type_o,
   input  logic [M*max_data_width-1:0]         y,
   output logic [M*max_data_width-1:0]         m_data,
   output logic                                m_valid,
   output logic                                busy,
   output logic                                done
);

   localparam int L  = (K-1) + CORE_LAT + (M-1);
   localparam int FW = $clog2(L+1);

   typedef enum logic [1:0] {IDLE, STREAM, FLUSH, DONE} state_t;

   state_t                              state, state_nx;
   logic [LEN_W-1:0]                    vc_q, acc_cnt, acc_nx;
   logic [FW-1:0]                       fl_cnt, fl_nx;
   logic [LOG_ALLOWED_PRECISIONS-1:0]   dt_q;
   logic [L-1:0]                        tok;
   logic                                mv_q;
   logic                                accept, advance;

   assign accept  = (state == STREAM) && s_valid;
   assign advance = accept || (state == FLUSH);

   always_comb begin
      state_nx = state;
      acc_nx   = acc_cnt;
      fl_nx    = fl_cnt;
      unique case (state)
         IDLE: begin
            if (start) begin
               acc_nx   = '0;
               fl_nx    = '0;
               state_nx = (vec_count == '0) ? DONE : STREAM;
            end
         end
         STREAM: begin
            if (accept) begin
               acc_nx = acc_cnt + LEN_W'(1);
               if (acc_nx == vc_q) state_nx = FLUSH;
            end
         end
         FLUSH: begin
            fl_nx = fl_cnt + FW'(1);
            if (fl_cnt == FW'(L-1)) state_nx = DONE;
         end
         DONE:    state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state   <= IDLE;
         vc_q    <= '0;
         acc_cnt <= '0;
         fl_cnt  <= '0;
         dt_q    <= '0;
         tok     <= '0;
         mv_q    <= 1'b0;
      end else begin
         state   <= state_nx;
         acc_cnt <= acc_nx;
         fl_cnt  <= fl_nx;
         if (state == IDLE && start) begin
            vc_q <= vec_count;
            dt_q <= data_type;
            tok  <= '0;
         end else if (advance) begin
            // a token leaving the tail marks a result present on y
            tok <= (tok << 1) | L'(accept);
         end
         mv_q <= advance && tok[L-1];
      end
   end

   assign s_ready       = (state == STREAM);
   assign input_data    = accept ? s_data : '0;
   assign enable        = advance;
   assign enable_in_ff  = advance;
   assign enable_chain  = advance;
   assign enable_out_ff = advance;
   assign data_type_o   = dt_q;
   assign m_valid       = mv_q;
   assign m_data        = mv_q ? y : '0;
   assign busy          = (state != IDLE);
   assign done          = (state == DONE);

endmodule

// File: tb/tb_mxu_feeder.sv
// tb_mxu_feeder: directed vector tables plus hand sequences for
// gap, empty, busy-start and mid-job reset behaviour of mxu_feeder.
module tb_mxu_feeder;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic [7:0]  vec_count = '0;
   logic [1:0]  data_type = '0;
   logic [11:0] s_data = '0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [11:0] input_data;
   logic        enable, enable_in_ff, enable_chain, enable_out_ff;
   logic [1:0]  data_type_o;
   logic [11:0] y = '0;
   logic [11:0] m_data;
   logic        m_valid, busy, done;

   mxu_feeder dut (
      .clk(clk), .reset(reset), .start(start), .vec_count(vec_count),
      .data_type(data_type), .s_data(s_data), .s_valid(s_valid),
      .s_ready(s_ready), .input_data(input_data), .enable(enable),
      .enable_in_ff(enable_in_ff), .enable_chain(enable_chain),
      .enable_out_ff(enable_out_ff), .data_type_o(data_type_o),
      .y(y), .m_data(m_data), .m_valid(m_valid), .busy(busy),
      .done(done)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        st;
      logic [7:0]  vc;
      logic        sv;
      logic [11:0] sd;
      logic [1:0]  dt;
      logic        rdy, en, mv, bsy, dn;
      logic [1:0]  edt;
   } vec_t;

   vec_t tab_b2b[$];
   vec_t tab_gap[$];
   int   tests = 0;
   int   fails = 0;

   function automatic vec_t mk(
      input logic st, input logic [7:0] vc, input logic sv,
      input logic [11:0] sd, input logic [1:0] dt,
      input logic rdy, input logic en, input logic mv,
      input logic bsy, input logic dn, input logic [1:0] edt);
      vec_t v;
      v.st = st; v.vc = vc; v.sv = sv; v.sd = sd; v.dt = dt;
      v.rdy = rdy; v.en = en; v.mv = mv; v.bsy = bsy; v.dn = dn;
      v.edt = edt;
      return v;
   endfunction

   function automatic logic [63:0] obs();
      return {30'b0, s_ready, enable, enable_in_ff, enable_chain,
              enable_out_ff, m_valid, busy, done, data_type_o,
              input_data, m_data};
   endfunction

   function automatic logic [63:0] expv(input vec_t v,
                                        input logic [11:0] yv);
      return {30'b0, v.rdy, {4{v.en}}, v.mv, v.bsy, v.dn, v.edt,
              (v.rdy && v.en) ? v.sd : 12'h0,
              v.mv ? yv : 12'h0};
   endfunction

   task automatic check(input string nm, input logic [63:0] act,
                        input logic [63:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic drive(input logic st, input logic [7:0] vc,
                        input logic sv, input logic [11:0] sd,
                        input logic [1:0] dt);
      @(negedge clk);
      start = st; vec_count = vc; s_valid = sv;
      s_data = sd; data_type = dt;
      y = 12'($urandom);
      #2;
   endtask

   task automatic run_tab(input string nm, input vec_t t[$]);
      for (int i = 0; i < t.size(); i++) begin
         drive(t[i].st, t[i].vc, t[i].sv, t[i].sd, t[i].dt);
         check($sformatf("%s[%0d]", nm, i), obs(), expv(t[i], y));
      end
   endtask

   task automatic run_job(input logic [7:0] vc, input logic [1:0] dt,
                          output int nmv, output bit got_done,
                          output bit last_mv);
      nmv = 0; got_done = 0; last_mv = 0;
      drive(1'b1, vc, 1'b1, 12'h0, dt);
      for (int c = 0; c < 40 && !got_done; c++) begin
         drive(1'b0, 8'd0, 1'b1, 12'($urandom), dt);
         if (m_valid) nmv++;
         if (done) begin
            got_done = 1;
            last_mv  = m_valid;
         end
      end
   endtask

   initial begin
      int nmv;
      bit gd, lm;

      // back-to-back, vec_count=4
      tab_b2b.push_back(mk(1,4,1,12'h101,2, 0,0,0,0,0, 0));
      for (int i = 1; i <= 4; i++)
         tab_b2b.push_back(mk(0,0,1,12'(12'h100+i),0, 1,1,0,1,0, 2));
      for (int i = 5; i <= 9; i++)
         tab_b2b.push_back(mk(0,0,1,12'h3C3,0, 0,1,(i>=7),1,0, 2));
      tab_b2b.push_back(mk(0,0,1,12'h3C3,0, 0,0,1,1,1, 2));
      tab_b2b.push_back(mk(0,0,1,12'h3C3,0, 0,0,0,0,0, 2));

      // gaps: vec_count=3, s_valid 1,0,0,1,1
      tab_gap.push_back(mk(1,3,0,12'h000,1, 0,0,0,0,0, 2));
      tab_gap.push_back(mk(0,0,1,12'hA11,0, 1,1,0,1,0, 1));
      tab_gap.push_back(mk(0,0,0,12'hA22,0, 1,0,0,1,0, 1));
      tab_gap.push_back(mk(0,0,0,12'hA33,0, 1,0,0,1,0, 1));
      tab_gap.push_back(mk(0,0,1,12'hA44,0, 1,1,0,1,0, 1));
      tab_gap.push_back(mk(0,0,1,12'hA55,0, 1,1,0,1,0, 1));
      for (int i = 6; i <= 10; i++)
         tab_gap.push_back(mk(0,0,0,12'h0,0, 0,1,(i>=9),1,0, 1));
      tab_gap.push_back(mk(0,0,0,12'h0,0, 0,0,1,1,1, 1));
      tab_gap.push_back(mk(0,0,0,12'h0,0, 0,0,0,0,0, 1));

      // reset state
      start = 1'b1; vec_count = 8'd5; s_valid = 1'b1;
      s_data = 12'hFFF; data_type = 2'd3; y = 12'hFFF;
      #3;
      check("reset_outputs", obs(), 64'h0);
      @(negedge clk);
      start = 1'b0;
      @(negedge clk);
      reset = 1'b1;

      run_tab("b2b", tab_b2b);
      run_tab("gap", tab_gap);

      // empty job
      drive(1'b1, 8'd0, 1'b1, 12'h5A5, 2'd3);
      check("empty_c0", {s_ready, enable, m_valid, busy, done}, 5'b00000);
      drive(1'b0, 8'd0, 1'b1, 12'h5A5, 2'd0);
      check("empty_c1", {s_ready, enable, m_valid, busy, done}, 5'b00011);
      check("empty_dt", 64'(data_type_o), 64'd3);
      drive(1'b0, 8'd0, 1'b1, 12'h5A5, 2'd0);
      check("empty_c2", {s_ready, enable, m_valid, busy, done}, 5'b00000);

      // start pulsed during STREAM is ignored
      drive(1'b1, 8'd2, 1'b0, 12'h0, 2'd2);
      drive(1'b0, 8'd0, 1'b0, 12'h0, 2'd0);
      drive(1'b1, 8'd7, 1'b1, 12'h0AA, 2'd3);
      nmv = 0; gd = 0; lm = 0;
      for (int c = 0; c < 40 && !gd; c++) begin
         drive(1'b0, 8'd0, 1'b1, 12'h0BB, 2'd0);
         if (m_valid) nmv++;
         if (done) begin
            gd = 1;
            lm = m_valid;
         end
      end
      check("busy_start_done", 64'(gd), 64'd1);
      check("busy_start_count", 64'(nmv), 64'd2);
      check("busy_start_last", 64'(lm), 64'd1);
      check("busy_start_dt", 64'(data_type_o), 64'd2);

      // reset during FLUSH
      drive(1'b1, 8'd3, 1'b1, 12'h0, 2'd1);
      for (int i = 0; i < 3; i++)
         drive(1'b0, 8'd0, 1'b1, 12'h111, 2'd0);
      drive(1'b0, 8'd0, 1'b0, 12'h0, 2'd0);
      drive(1'b0, 8'd0, 1'b0, 12'h0, 2'd0);
      check("pre_reset_flush", {s_ready, enable, busy}, 3'b011);
      #1 reset = 1'b0;
      #1 check("async_reset", obs(), 64'h0);
      @(negedge clk);
      @(negedge clk);
      reset = 1'b1;
      nmv = 0; gd = 0;
      for (int c = 0; c < 12; c++) begin
         drive(1'b0, 8'd0, 1'b0, 12'h0, 2'd0);
         if (m_valid) nmv++;
         if (done) gd = 1;
      end
      check("post_reset_no_mv", 64'(nmv), 64'd0);
      check("post_reset_no_done", 64'(gd), 64'd0);
      run_job(8'd2, 2'd2, nmv, gd, lm);
      check("new_job_done", 64'(gd), 64'd1);
      check("new_job_count", 64'(nmv), 64'd2);
      check("new_job_last", 64'(lm), 64'd1);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
